// File: rtl/matrix_drain_pkg.sv
// matrix_drain_pkg: shared constants, FSM states and drain-order lookup for the result drain
package matrix_drain_pkg;
  localparam int N_ELEM = 9;
  localparam int ELEM_W = 8;
  localparam int ORDER_ROW = 0;
  localparam int ORDER_COL = 1;
  typedef enum logic {IDLE, STREAM} drain_state_t;
  localparam logic [3:0] COL_LUT [N_ELEM] = '{4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8};
endpackage

// File: rtl/drain_frame_buf.sv
// drain_frame_buf: one 3x3 result frame held as a 9x8 register bank with indexed read
module drain_frame_buf
  import matrix_drain_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [N_ELEM*ELEM_W-1:0] din,
  input  logic [3:0]               idx,
  output logic [ELEM_W-1:0]        dout
);
  logic [N_ELEM-1:0][ELEM_W-1:0] mem;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mem <= '0;
    else if (load) mem <= din;
  assign dout = mem[idx];
endmodule

// File: rtl/matrix_result_drain.sv
// matrix_result_drain: captures the nine multiplier results on done rise and streams them over valid/ready
// Optional DRAIN_FRAME_CNT_EN adds an 8-bit count of completed frames.
module matrix_result_drain
  import matrix_drain_pkg::*;
#(
  parameter int ORDER  = ORDER_ROW,
  parameter int ELEM_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done_in,
  input  logic [N_ELEM*ELEM_W-1:0] results_in,
  input  logic                     out_ready,
  input  logic                     overrun_clr,
  output logic                     out_valid,
  output logic [ELEM_W-1:0]        out_data,
  output logic [3:0]               out_index,
  output logic                     out_last,
  output logic                     busy,
`ifdef DRAIN_FRAME_CNT_EN
  output logic [7:0]               frame_count,
`endif
  output logic                     overrun
);
  drain_state_t state, state_d;
  logic [3:0] p, p_d, idx;
  logic sel, sel_d, shadow_full, sf_d, ov_d, done_q, done_rise, hs, final_hs;
  logic ld_cur, ld_oth;
  logic [ELEM_W-1:0] rd0, rd1;
  assign done_rise = done_in & ~done_q;
  assign out_valid = state == STREAM;
  assign hs        = out_valid & out_ready;
  assign final_hs  = hs & (p == 4'd8);
  // sel names the active buffer; the other one is the shadow
  always_comb begin
    state_d = state;
    p_d     = p;
    sel_d   = sel;
    sf_d    = shadow_full;
    ov_d    = overrun & ~overrun_clr;
    ld_cur  = 1'b0;
    ld_oth  = 1'b0;
    if (state == IDLE) begin
      if (done_rise) begin
        ld_cur  = 1'b1;
        state_d = STREAM;
        p_d     = '0;
      end
    end else if (final_hs) begin
      p_d = '0;
      if (shadow_full) begin
        sel_d  = ~sel;
        ld_cur = done_rise;
        sf_d   = done_rise;
      end else begin
        ld_cur  = done_rise;
        state_d = done_rise ? STREAM : IDLE;
      end
    end else begin
      if (hs) p_d = p + 4'd1;
      if (done_rise) begin
        if (shadow_full) ov_d = 1'b1;
        else begin
          ld_oth = 1'b1;
          sf_d   = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      p           <= '0;
      sel         <= 1'b0;
      shadow_full <= 1'b0;
      overrun     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      p           <= p_d;
      sel         <= sel_d;
      shadow_full <= sf_d;
      overrun     <= ov_d;
      done_q      <= done_in;
    end
`ifdef DRAIN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) frame_count <= '0;
    else if (final_hs) frame_count <= frame_count + 8'd1;
`endif
  assign idx = (ORDER == ORDER_COL) ? COL_LUT[p] : p;
  drain_frame_buf u_buf0 (
    .clk(clk), .reset(reset), .load((ld_cur & ~sel) | (ld_oth & sel)),
    .din(results_in), .idx(idx), .dout(rd0)
  );
  drain_frame_buf u_buf1 (
    .clk(clk), .reset(reset), .load((ld_cur & sel) | (ld_oth & ~sel)),
    .din(results_in), .idx(idx), .dout(rd1)
  );
  assign out_data  = out_valid ? (sel ? rd1 : rd0) : '0;
  assign out_index = p;
  assign out_last  = out_valid & (p == 4'd8);
  assign busy      = out_valid | shadow_full;
endmodule
